// File: rtl/ntsc_pkg.sv
// ntsc_pkg: shared constants and types for the NTSC timing generator.
// Holds the default line/frame timing, counter widths, the vertical
// state encoding and a small window-compare helper.
package ntsc_pkg;

    // Default timing at the 32 MHz pixel clock.
    localparam int DEF_H_TOTAL        = 2034;
    localparam int DEF_H_SYNC         = 150;
    localparam int DEF_H_BURST_START  = 170;
    localparam int DEF_H_BURST_LEN    = 80;
    localparam int DEF_H_ACTIVE_START = 320;
    localparam int DEF_H_ACTIVE_LEN   = 1600;
    localparam int DEF_V_TOTAL        = 262;
    localparam int DEF_V_ACTIVE_START = 21;
    localparam int DEF_V_ACTIVE_LEN   = 240;

    // Fixed vertical sync structure: three lines each of EQ1, VSYNC, EQ2.
    localparam int V_EQ1_LAST    = 2;
    localparam int V_VSYNC_LAST  = 5;
    localparam int V_EQ2_LAST    = 8;
    localparam int V_VBLANK_FIRST = 9;

    // Counter and coordinate widths.
    localparam int H_CNT_W = 11;
    localparam int V_CNT_W = 9;
    localparam int PX_W    = 11;
    localparam int PY_W    = 9;

    typedef enum logic [2:0] {
        EQ1    = 3'd0,
        VSYNC  = 3'd1,
        EQ2    = 3'd2,
        VBLANK = 3'd3,
        ACTIVE = 3'd4,
        POST   = 3'd5
    } vstate_e;

    // True when lo <= pos < hi.
    function automatic logic in_window(input logic [H_CNT_W-1:0] pos,
                                       input logic [H_CNT_W-1:0] lo,
                                       input logic [H_CNT_W-1:0] hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/ntsc_timing_gen_if.sv
// ntsc_timing_gen_if: video timing bundle from the generator (master)
// to the chroma/luma stages and framebuffer fetch logic (slave).
interface ntsc_timing_gen_if;
    import ntsc_pkg::*;

    logic            sync_n;
    logic            cb_dly;
    logic            active_dly;
    logic            pixel_req;
    logic [PX_W-1:0] pixel_x;
    logic [PY_W-1:0] pixel_y;
    logic            line_start;
    logic            frame_start;

    modport master (
        output sync_n, cb_dly, active_dly, pixel_req,
        output pixel_x, pixel_y, line_start, frame_start
    );

    modport slave (
        input sync_n, cb_dly, active_dly, pixel_req,
        input pixel_x, pixel_y, line_start, frame_start
    );
endinterface

// File: rtl/ntsc_sync_shaper.sv
// ntsc_sync_shaper: maps (h_cnt, vertical state) to the registered
// composite sync level. Build option NTSC_TIMING_SERRATION_EN adds
// equalizing pulses on EQ1/EQ2 lines and serrated broad pulses on VSYNC
// lines; without it EQ lines carry plain hsync and VSYNC lines a single
// broad pulse.
module ntsc_sync_shaper
    import ntsc_pkg::*;
#(
    parameter int H_TOTAL = DEF_H_TOTAL,
    parameter int H_SYNC  = DEF_H_SYNC
) (
    input  logic               clk_2x,
    input  logic               reset_n,
    input  logic [H_CNT_W-1:0] h_cnt,
    input  vstate_e            vstate,
    output logic               sync_n
);

    localparam logic [H_CNT_W-1:0] HS_END    = H_CNT_W'(H_SYNC);
    localparam logic [H_CNT_W-1:0] BROAD_END = H_CNT_W'(H_TOTAL - H_SYNC);
`ifdef NTSC_TIMING_SERRATION_EN
    localparam logic [H_CNT_W-1:0] EQ_END      = H_CNT_W'(H_SYNC / 2);
    localparam logic [H_CNT_W-1:0] HALF        = H_CNT_W'(H_TOTAL / 2);
    localparam logic [H_CNT_W-1:0] HALF_EQ_END = H_CNT_W'(H_TOTAL / 2 + H_SYNC / 2);
    localparam logic [H_CNT_W-1:0] SERR_START  = H_CNT_W'(H_TOTAL / 2 - H_SYNC);
    localparam logic [H_CNT_W-1:0] LINE_END    = H_CNT_W'(H_TOTAL);
`endif

    logic sync_low_s;
    logic sync_n_r;

    // Decide whether the line is at sync tip for this position and state.
    always_comb begin
        sync_low_s = 1'b0;
        case (vstate)
            EQ1, EQ2: begin
`ifdef NTSC_TIMING_SERRATION_EN
                sync_low_s = (h_cnt < EQ_END) || in_window(h_cnt, HALF, HALF_EQ_END);
`else
                sync_low_s = (h_cnt < HS_END);
`endif
            end
            VSYNC: begin
`ifdef NTSC_TIMING_SERRATION_EN
                sync_low_s = !(in_window(h_cnt, SERR_START, HALF) ||
                               in_window(h_cnt, BROAD_END, LINE_END));
`else
                sync_low_s = (h_cnt < BROAD_END);
`endif
            end
            default: begin
                sync_low_s = (h_cnt < HS_END);
            end
        endcase
    end

    // Register the sync level; blanking level while in reset.
    always_ff @(posedge clk_2x or negedge reset_n) begin
        if (!reset_n) begin
            sync_n_r <= 1'b1;
        end else begin
            sync_n_r <= ~sync_low_s;
        end
    end

    assign sync_n = sync_n_r;

endmodule

// File: rtl/ntsc_timing_gen.sv
// ntsc_timing_gen: NTSC horizontal/vertical timing generator.
// Counts pixels and lines, runs the vertical FSM, and registers sync,
// burst window, active window and pixel coordinates. pixel_req/x/y lead
// active_dly/cb_dly by one clock so the framebuffer can fetch in between.
// Optional feature: NTSC_TIMING_SERRATION_EN (see ntsc_sync_shaper).
module ntsc_timing_gen
    import ntsc_pkg::*;
#(
    parameter int H_TOTAL        = DEF_H_TOTAL,
    parameter int H_SYNC         = DEF_H_SYNC,
    parameter int H_BURST_START  = DEF_H_BURST_START,
    parameter int H_BURST_LEN    = DEF_H_BURST_LEN,
    parameter int H_ACTIVE_START = DEF_H_ACTIVE_START,
    parameter int H_ACTIVE_LEN   = DEF_H_ACTIVE_LEN,
    parameter int V_TOTAL        = DEF_V_TOTAL,
    parameter int V_ACTIVE_START = DEF_V_ACTIVE_START,
    parameter int V_ACTIVE_LEN   = DEF_V_ACTIVE_LEN
) (
    input  logic               clk_2x,
    input  logic               reset_n,
    ntsc_timing_gen_if.master  vid
);

    generate
        if (H_ACTIVE_START + H_ACTIVE_LEN >= H_TOTAL) begin : g_bad_h_active
            $error("ntsc_timing_gen: active window must end before H_TOTAL");
        end
        if (H_BURST_START + H_BURST_LEN > H_ACTIVE_START) begin : g_bad_burst
            $error("ntsc_timing_gen: burst window overlaps active video");
        end
        if (V_ACTIVE_START + V_ACTIVE_LEN > V_TOTAL) begin : g_bad_v_active
            $error("ntsc_timing_gen: active lines exceed V_TOTAL");
        end
    endgenerate

    localparam logic [H_CNT_W-1:0] H_ZERO     = H_CNT_W'(0);
    localparam logic [H_CNT_W-1:0] H_LAST     = H_CNT_W'(H_TOTAL - 1);
    localparam logic [H_CNT_W-1:0] BURST_LO   = H_CNT_W'(H_BURST_START);
    localparam logic [H_CNT_W-1:0] BURST_HI   = H_CNT_W'(H_BURST_START + H_BURST_LEN);
    localparam logic [H_CNT_W-1:0] ACT_H_LO   = H_CNT_W'(H_ACTIVE_START);
    localparam logic [H_CNT_W-1:0] ACT_H_HI   = H_CNT_W'(H_ACTIVE_START + H_ACTIVE_LEN);
    localparam logic [V_CNT_W-1:0] V_ZERO     = V_CNT_W'(0);
    localparam logic [V_CNT_W-1:0] V_LAST     = V_CNT_W'(V_TOTAL - 1);
    localparam logic [V_CNT_W-1:0] V_EQ1_END  = V_CNT_W'(V_EQ1_LAST);
    localparam logic [V_CNT_W-1:0] V_VS_END   = V_CNT_W'(V_VSYNC_LAST);
    localparam logic [V_CNT_W-1:0] V_EQ2_END  = V_CNT_W'(V_EQ2_LAST);
    localparam logic [V_CNT_W-1:0] V_VBL_END  = V_CNT_W'(V_ACTIVE_START - 1);
    localparam logic [V_CNT_W-1:0] V_ACT_LO   = V_CNT_W'(V_ACTIVE_START);
    localparam logic [V_CNT_W-1:0] V_ACT_END  = V_CNT_W'(V_ACTIVE_START + V_ACTIVE_LEN - 1);
    // With no blanking lines between EQ2 and the picture, skip VBLANK.
    localparam vstate_e AFTER_EQ2 = (V_ACTIVE_START > V_VBLANK_FIRST) ? VBLANK : ACTIVE;

    logic [H_CNT_W-1:0] h_cnt_r;
    logic [V_CNT_W-1:0] v_cnt_r;
    vstate_e            vstate_r;
    vstate_e            vstate_nxt_s;
    logic               line_end_s;
    logic               burst_line_s;
    logic               active_line_s;
    logic               pixel_req_s;
    logic               burst_s;

    logic               pixel_req_r;
    logic [PX_W-1:0]    pixel_x_r;
    logic [PY_W-1:0]    pixel_y_r;
    logic               line_start_r;
    logic               frame_start_r;
    logic               cb_stage_r;
    logic               cb_dly_r;
    logic               active_dly_r;
    logic               sync_n_s;

    assign line_end_s = (h_cnt_r == H_LAST);

    // Pixel and line counters; line count advances on the last pixel.
    always_ff @(posedge clk_2x or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt_r <= H_ZERO;
            v_cnt_r <= V_ZERO;
        end else if (line_end_s) begin
            h_cnt_r <= H_ZERO;
            v_cnt_r <= (v_cnt_r == V_LAST) ? V_ZERO : v_cnt_r + V_CNT_W'(1);
        end else begin
            h_cnt_r <= h_cnt_r + H_CNT_W'(1);
        end
    end

    // Vertical FSM state register.
    always_ff @(posedge clk_2x or negedge reset_n) begin
        if (!reset_n) begin
            vstate_r <= EQ1;
        end else begin
            vstate_r <= vstate_nxt_s;
        end
    end

    // Vertical FSM next state; transitions only at the end of a line.
    always_comb begin
        vstate_nxt_s = vstate_r;
        if (line_end_s) begin
            case (vstate_r)
                EQ1: begin
                    if (v_cnt_r == V_EQ1_END) vstate_nxt_s = VSYNC;
                    else                      vstate_nxt_s = EQ1;
                end
                VSYNC: begin
                    if (v_cnt_r == V_VS_END) vstate_nxt_s = EQ2;
                    else                     vstate_nxt_s = VSYNC;
                end
                EQ2: begin
                    if (v_cnt_r == V_EQ2_END) vstate_nxt_s = AFTER_EQ2;
                    else                      vstate_nxt_s = EQ2;
                end
                VBLANK: begin
                    if (v_cnt_r == V_VBL_END) vstate_nxt_s = ACTIVE;
                    else                      vstate_nxt_s = VBLANK;
                end
                ACTIVE: begin
                    if (v_cnt_r == V_LAST)         vstate_nxt_s = EQ1;
                    else if (v_cnt_r == V_ACT_END) vstate_nxt_s = POST;
                    else                           vstate_nxt_s = ACTIVE;
                end
                POST: begin
                    if (v_cnt_r == V_LAST) vstate_nxt_s = EQ1;
                    else                   vstate_nxt_s = POST;
                end
                default: begin
                    vstate_nxt_s = EQ1;
                end
            endcase
        end else begin
            vstate_nxt_s = vstate_r;
        end
    end

    // Vertical FSM outputs: which line types carry burst and picture.
    always_comb begin
        burst_line_s  = 1'b0;
        active_line_s = 1'b0;
        case (vstate_r)
            VBLANK, POST: begin
                burst_line_s = 1'b1;
            end
            ACTIVE: begin
                burst_line_s  = 1'b1;
                active_line_s = 1'b1;
            end
            default: begin
                burst_line_s  = 1'b0;
                active_line_s = 1'b0;
            end
        endcase
    end

    assign pixel_req_s = active_line_s && in_window(h_cnt_r, ACT_H_LO, ACT_H_HI);
    assign burst_s     = burst_line_s && in_window(h_cnt_r, BURST_LO, BURST_HI);

    // First output stage: decode of the current counter position.
    always_ff @(posedge clk_2x or negedge reset_n) begin
        if (!reset_n) begin
            pixel_req_r   <= 1'b0;
            pixel_x_r     <= PX_W'(0);
            pixel_y_r     <= PY_W'(0);
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
            cb_stage_r    <= 1'b0;
        end else begin
            pixel_req_r   <= pixel_req_s;
            line_start_r  <= (h_cnt_r == H_ZERO);
            frame_start_r <= (h_cnt_r == H_ZERO) && (v_cnt_r == V_ZERO);
            cb_stage_r    <= burst_s;
            // Coordinates hold outside the active window.
            if (pixel_req_s) begin
                pixel_x_r <= PX_W'(h_cnt_r - ACT_H_LO);
                pixel_y_r <= PY_W'(v_cnt_r - V_ACT_LO);
            end
        end
    end

    // Second stage: burst and active aligned with fetched pixel data.
    always_ff @(posedge clk_2x or negedge reset_n) begin
        if (!reset_n) begin
            cb_dly_r     <= 1'b0;
            active_dly_r <= 1'b0;
        end else begin
            cb_dly_r     <= cb_stage_r;
            active_dly_r <= pixel_req_r;
        end
    end

    ntsc_sync_shaper #(
        .H_TOTAL (H_TOTAL),
        .H_SYNC  (H_SYNC)
    ) u_sync_shaper (
        .clk_2x  (clk_2x),
        .reset_n (reset_n),
        .h_cnt   (h_cnt_r),
        .vstate  (vstate_r),
        .sync_n  (sync_n_s)
    );

    assign vid.sync_n      = sync_n_s;
    assign vid.cb_dly      = cb_dly_r;
    assign vid.active_dly  = active_dly_r;
    assign vid.pixel_req   = pixel_req_r;
    assign vid.pixel_x     = pixel_x_r;
    assign vid.pixel_y     = pixel_y_r;
    assign vid.line_start  = line_start_r;
    assign vid.frame_start = frame_start_r;

endmodule

// File: doc/ntsc_timing_gen.md
# ntsc_timing_gen

Horizontal and vertical timing generator for the NTSC composite output path. It runs on the 32 MHz pixel clock and counts lines and frames. It drives the sync level, the colour-burst window and the active-video window that the chroma oscillator and luma stage consume. It also issues pixel coordinates one clock ahead, so the framebuffer has a cycle to fetch before `active_dly` is asserted.

## Interface
- `H_TOTAL`, 2034: clocks per line (63.56 us at 32 MHz).
- `H_SYNC`, 150: horizontal sync width in clocks (4.7 us).
- `H_BURST_START`, 170: first clock of the burst window after the line start.
- `H_BURST_LEN`, 80: burst window length in clocks (about 9 subcarrier cycles).
- `H_ACTIVE_START`, 320: first active clock in the line.
- `H_ACTIVE_LEN`, 1600: number of active clocks per line.
- `V_TOTAL`, 262: lines per frame (progressive).
- `V_ACTIVE_START`, 21: first active line.
- `V_ACTIVE_LEN`, 240: number of active lines.
- `clk_2x`  in  1  pixel clock, 32 MHz.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sync_n`  out  1  composite sync level; 0 means sync tip.
- `cb_dly`  out  1  colour-burst enable, aligned with `active_dly`.
- `active_dly`  out  1  active video, 1 clock after `pixel_req`.
- `pixel_req`  out  1  fetch strobe for (`pixel_x`, `pixel_y`).
- `pixel_x`  out  11  active column, 0..H_ACTIVE_LEN-1.
- `pixel_y`  out  9  active row, 0..V_ACTIVE_LEN-1.
- `line_start`  out  1  one-clock pulse at h=0.
- `frame_start`  out  1  one-clock pulse at h=0, v=0.

## Operation
- `h_cnt` counts 0..H_TOTAL-1 and wraps. `v_cnt` increments when `h_cnt` = H_TOTAL-1 and wraps after V_TOTAL-1.
- The vertical FSM advances only at end of line:
  - EQ1 covers lines 0-2.
  - VSYNC covers lines 3-5.
  - EQ2 covers lines 6-8.
  - VBLANK runs from line 9 to V_ACTIVE_START-1.
  - ACTIVE covers V_ACTIVE_LEN lines.
  - POST runs to V_TOTAL-1, then returns to EQ1.
- Sync in VBLANK, ACTIVE and POST: `sync_n`=0 for `h_cnt` < H_SYNC.
- Colour burst: enabled for H_BURST_START ≤ `h_cnt` < H_BURST_START+H_BURST_LEN in VBLANK, ACTIVE and POST. Burst is suppressed in EQ1, VSYNC and EQ2.
- Active video:
  - `pixel_req`=1 only in ACTIVE with H_ACTIVE_START ≤ `h_cnt` < H_ACTIVE_START+H_ACTIVE_LEN.
  - `pixel_x` = `h_cnt`-H_ACTIVE_START.
  - `pixel_y` = `v_cnt`-V_ACTIVE_START.
  - `pixel_x`/`pixel_y` hold their last value when `pixel_req`=0.
- Simultaneous events: at v=0, h=0 both `line_start` and `frame_start` pulse in the same clock.
- Reset values: `h_cnt`=0, `v_cnt`=0, FSM=EQ1, `sync_n`=1, `cb_dly`=0, `active_dly`=0, `pixel_req`=0, `pixel_x`=0, `pixel_y`=0, `line_start`=0, `frame_start`=0.
- Reset asserted mid-line forces these values immediately (asynchronous). The first clock after release is h=0, v=0, and `frame_start`=1 in that clock.
- Parameter constraints, checked by elaboration assertion:
  - H_ACTIVE_START+H_ACTIVE_LEN < H_TOTAL.
  - H_BURST_START+H_BURST_LEN ≤ H_ACTIVE_START.
  - V_ACTIVE_START+V_ACTIVE_LEN ≤ V_TOTAL.

## Timing
- All outputs are registered. Decode for counter value (h,v) appears on `sync_n`, `pixel_req`, `pixel_x`, `pixel_y`, `line_start` and `frame_start` one clock after the counters hold (h,v).
- `active_dly` and `cb_dly` appear one clock later still, so they are aligned with the fetched pixel data.
- `sync_n` is not additionally delayed. Luma/sync alignment with chroma is done downstream.
- Frame period is H_TOTAL×V_TOTAL = 532,908 clocks.

## Configuration
- Macro: `NTSC_TIMING_SERRATION_EN`.
- When defined:
  - EQ1 and EQ2 lines carry equalizing pulses: `sync_n`=0 for `h_cnt` < H_SYNC/2 and for H_TOTAL/2 ≤ `h_cnt` < H_TOTAL/2+H_SYNC/2.
  - VSYNC lines carry serrated broad pulses: `sync_n`=0 except for H_TOTAL/2-H_SYNC ≤ `h_cnt` < H_TOTAL/2 and H_TOTAL-H_SYNC ≤ `h_cnt` < H_TOTAL.
- When undefined:
  - EQ1 and EQ2 use normal hsync.
  - VSYNC lines hold `sync_n`=0 for `h_cnt` < H_TOTAL-H_SYNC.

## Structure
- Package `ntsc_pkg`:
  - Default timing localparams.
  - Vertical state enum (EQ1, VSYNC, EQ2, VBLANK, ACTIVE, POST).
  - Counter width constants.
- Sub-module `ntsc_sync_shaper`: combinational-plus-register mapping of (`h_cnt`, state) to `sync_n`. It contains the `NTSC_TIMING_SERRATION_EN` logic.

## Test plan
- Reset released → `frame_start` and `line_start` high in the same clock; next `frame_start` exactly 532,908 clocks later; `sync_n` low for 150 clocks per line in ACTIVE.
- Line 21 → `pixel_req` high for exactly 1600 clocks starting at h=320, `pixel_x` 0→1599, `pixel_y`=0; `active_dly` is the same pulse delayed 1 clock.
- Line 100 → `cb_dly` high for 80 clocks ending before `active_dly` rises; lines 0-8 → `cb_dly` never high.
- With the macro, line 4 → `sync_n` high only on h∈[867,1016] and [1884,2033]; without it, `sync_n` high only on h∈[1884,2033].
- `reset_n` pulsed low at line 150, h=900 → all outputs at reset values within the same clock; restart from v=0.
- Line 260 (last active line) → `pixel_y`=239; line 261 → no `pixel_req`; the FSM wraps to EQ1 with `frame_start`.
